// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch predictor for the 5-stage pipeline: a direct-mapped BTB with
//   a 2-bit saturating counter per entry. IF looks up the current PC with zero
//   latency; EX reports each resolved branch, which trains the table and yields
//   the mispredict flush request plus the corrected next PC.
//
//   Optional feature macro: BP_STATS_EN adds saturating branch/mispredict
//   counters (stat_branches, stat_mispred).
//
// Ports
//   clk             in   rising-edge clock
//   rst             in   asynchronous active-low reset
//   lu_pc           in   IF-stage PC to look up
//   lu_hit          out  valid entry with matching tag
//   lu_taken        out  lu_hit and counter MSB
//   lu_target       out  stored target (0 on miss)
//   upd_valid       in   EX resolves a branch this cycle
//   upd_pc          in   PC of the resolved branch
//   upd_taken       in   actual outcome
//   upd_target      in   actual taken target
//   upd_pred_taken  in   prediction carried with the branch
//   upd_pred_target in   predicted target carried with the branch
//   mispredict      out  flush request
//   redirect_pc     out  correct next PC (0 when upd_valid=0)
//   stat_branches   out  [BP_STATS_EN] resolved-branch count, saturating
//   stat_mispred    out  [BP_STATS_EN] mispredict count, saturating
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int          ADDR_W    = 32,
  parameter int          ENTRIES   = 16,
  parameter logic [1:0]  ALLOC_CTR = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lu_pc,
  output logic              lu_hit,
  output logic              lu_taken,
  output logic [ADDR_W-1:0] lu_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  output logic              mispredict,
  output logic [ADDR_W-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispred
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lu_idx;
  logic [TAG_W-1:0] lu_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;

  // Instructions are word aligned, so the low PC bits carry no information.
  logic unused_lu_pc_bits;
  assign unused_lu_pc_bits = ^lu_pc[1:0];

  assign lu_idx  = lu_pc[IDX_W+1:2];
  assign lu_tag  = lu_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update to the same
  // index is seen by IF one cycle later.
  assign lu_hit    = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
  assign lu_taken  = lu_hit && ctr_q[lu_idx][1];
  assign lu_target = lu_hit ? target_q[lu_idx] : '0;

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));

  // pc+4 wraps modulo 2^ADDR_W by construction.
  assign redirect_pc = !upd_valid ? '0 :
                       upd_taken  ? upd_target : (upd_pc + PC_STEP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (ctr_q[upd_idx] != 2'b11) ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'b01;
          target_q[upd_idx] <= upd_target;
        end else if (ctr_q[upd_idx] != 2'b00) begin
          ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        // Direct-mapped: a taken miss simply overwrites whatever lives here.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= ALLOC_CTR;
      end
    end
  end

`ifdef BP_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (upd_valid && (stat_branches != 32'hFFFF_FFFF))
        stat_branches <= stat_branches + 32'd1;
      if (mispredict && (stat_mispred != 32'hFFFF_FFFF))
        stat_mispred <= stat_mispred + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//   Directed-vector bench for branch_predictor (default parameters, ENTRIES=16).
//   Inputs change 1 time unit after a rising edge; outputs are sampled 2 units
//   later, well clear of any edge.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] lu_pc;
  logic        lu_hit;
  logic        lu_taken;
  logic [31:0] lu_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor dut (
    .clk             (clk),
    .rst             (rst),
    .lu_pc           (lu_pc),
    .lu_hit          (lu_hit),
    .lu_taken        (lu_taken),
    .lu_target       (lu_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
`ifdef BP_STATS_EN
    ,
    .stat_branches   (stat_branches),
    .stat_mispred    (stat_mispred)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply an update vector and let the combinational outputs settle.
  task automatic drive(input logic v, input logic [31:0] pc, input logic tk,
                       input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    upd_valid       = v;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic look(input logic [31:0] pc);
    lu_pc = pc;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    lu_pc = 32'h40;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
    #3;
    chk("in_reset_hit", {31'b0, lu_hit}, 32'h0);
    chk("in_reset_target", lu_target, 32'h0);
    #9 rst = 1'b1;
    tick();

    // Reset defaults.
    idle();
    chk("rst_hit", {31'b0, lu_hit}, 32'h0);
    chk("rst_taken", {31'b0, lu_taken}, 32'h0);
    chk("rst_target", lu_target, 32'h0);
    chk("rst_mispredict", {31'b0, mispredict}, 32'h0);
    chk("rst_redirect", redirect_pc, 32'h0);

    // upd_valid=0 masks everything, even a would-be mispredicting vector.
    drive(1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("novalid_mispredict", {31'b0, mispredict}, 32'h0);
    chk("novalid_redirect", redirect_pc, 32'h0);
    tick();
    idle();
    chk("novalid_nostate", {31'b0, lu_hit}, 32'h0);

    // Allocate 0x40 -> 0x100 (counter 10).
    tick();
    drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("alloc_mispredict", {31'b0, mispredict}, 32'h1);
    chk("alloc_redirect", redirect_pc, 32'h100);
    tick();
    idle();
    chk("alloc_hit", {31'b0, lu_hit}, 32'h1);
    chk("alloc_taken", {31'b0, lu_taken}, 32'h1);
    chk("alloc_target", lu_target, 32'h100);

    // Correctly predicted taken: 10 -> 11, then saturate at 11.
    drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    chk("correct_taken_nomis", {31'b0, mispredict}, 32'h0);
    tick();
    drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    tick();
    drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);
    tick();

    // First not-taken: 11 -> 10, still predicts taken; target must not change.
    drive(1'b1, 32'h40, 1'b0, 32'h999, 1'b1, 32'h100);
    chk("nt1_mispredict", {31'b0, mispredict}, 32'h1);
    chk("nt1_redirect", redirect_pc, 32'h44);
    tick();
    idle();
    chk("nt1_taken_sat_hi", {31'b0, lu_taken}, 32'h1);
    chk("nt1_target_kept", lu_target, 32'h100);

    // 10 -> 01 -> 00 -> 00 (saturate low).
    drive(1'b1, 32'h40, 1'b0, 32'h999, 1'b1, 32'h100);
    tick();
    idle();
    chk("nt2_taken", {31'b0, lu_taken}, 32'h0);
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("nt3_nomis", {31'b0, mispredict}, 32'h0);
    tick();
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    // One taken from 00 reaches only 01.
    drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    idle();
    chk("sat_lo_taken", {31'b0, lu_taken}, 32'h0);
    chk("sat_lo_hit", {31'b0, lu_hit}, 32'h1);

    // Not-taken miss allocates nothing.
    drive(1'b1, 32'h44, 1'b0, 32'h700, 1'b0, 32'h0);
    tick();
    idle();
    look(32'h44);
    chk("nt_miss_noalloc", {31'b0, lu_hit}, 32'h0);

    // Aliasing: 0x80 shares index 0 with 0x40.
    look(32'h80);
    chk("alias_miss", {31'b0, lu_hit}, 32'h0);
    drive(1'b1, 32'h80, 1'b1, 32'h200, 1'b0, 32'h0);
    chk("alias_mispredict", {31'b0, mispredict}, 32'h1);
    tick();
    idle();
    chk("alias_new_target", lu_target, 32'h200);
    chk("alias_new_taken", {31'b0, lu_taken}, 32'h1);
    look(32'h40);
    chk("alias_evicted", {31'b0, lu_hit}, 32'h0);

    // Re-establish 0x40 -> 0x100, then retarget to 0x300 while looking it up.
    drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h40, 1'b1, 32'h300, 1'b1, 32'h100);
    chk("conflict_old_target", lu_target, 32'h100);
    chk("tgt_change_mispredict", {31'b0, mispredict}, 32'h1);
    chk("tgt_change_redirect", redirect_pc, 32'h300);
    tick();
    idle();
    chk("conflict_new_target", lu_target, 32'h300);

    // redirect wraps modulo 2^32.
    drive(1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0, 1'b1, 32'h0);
    chk("wrap_redirect", redirect_pc, 32'h0000_0002);
    tick();

    // Mid-run reset with a coinciding taken update that must be discarded.
    drive(1'b1, 32'h40, 1'b1, 32'h500, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    chk("midrst_hit", {31'b0, lu_hit}, 32'h0);
    chk("midrst_target", lu_target, 32'h0);
    tick();
    rst = 1'b1;
    idle();
    chk("midrst_upd_discarded", {31'b0, lu_hit}, 32'h0);

`ifdef BP_STATS_EN
    chk("stat_br_cleared", stat_branches, 32'd0);
    chk("stat_mis_cleared", stat_mispred, 32'd0);
    tick();
    drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b0, 32'h0);    // mispredict
    tick();
    drive(1'b1, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100);  // correct
    tick();
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 32'h100);    // mispredict
    tick();
    drive(1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);      // correct
    tick();
    drive(1'b1, 32'h48, 1'b0, 32'h0, 1'b0, 32'h0);      // correct
    tick();
    idle();
    chk("stat_branches", stat_branches, 32'd5);
    chk("stat_mispred", stat_mispred, 32'd2);
    rst = 1'b0;
    #1;
    chk("stat_br_rst", stat_branches, 32'd0);
    chk("stat_mis_rst", stat_mispred, 32'd0);
    #1 rst = 1'b1;
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage pipeline. It replaces the fixed predict-not-taken / flush-on-EX-branch scheme.
- IF stage looks up the current PC combinationally and gets a predicted-taken flag and target.
- EX stage reports each resolved branch. The block trains a direct-mapped BTB with 2-bit saturating counters.
- It also produces the mispredict flag and the redirect PC that drive the IF/ID and ID/EX flushes.

Parameters:
- ADDR_W, 32, PC/target width in bits.
- ENTRIES, 16, BTB entries; power of two, >=2. IDX_W = log2(ENTRIES) and TAG_W = ADDR_W-2-IDX_W are derived localparams.
- ALLOC_CTR, 2'b10, counter value written when a new entry is allocated.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- lu_pc  in  ADDR_W  IF-stage PC to look up.
- lu_hit  out  1  valid entry with matching tag.
- lu_taken  out  1  lu_hit & counter[1].
- lu_target  out  ADDR_W  stored target (0 when !lu_hit).
- upd_valid  in  1  EX stage resolves a branch this cycle.
- upd_pc  in  ADDR_W  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_W  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipe with the branch.
- upd_pred_target  in  ADDR_W  predicted target carried down the pipe.
- mispredict  out  1  flush request.
- redirect_pc  out  ADDR_W  correct next PC when mispredict=1.

Behaviour:
- Indexing: idx = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] ignored.
- Storage per entry: valid, tag, target, 2-bit counter. Async reset clears all valid bits; counters to 2'b01, targets/tags to 0.
- Lookup: purely combinational from registered state, zero latency.
  - Lookup in the same cycle as an update to the same index returns the pre-update (old) state.
  - All lookup outputs are 0 during reset.
- Update: takes effect on the rising clk edge when upd_valid=1.
  - Hit (valid & tag match): counter increments if taken, saturating at 2'b11; decrements if not taken, saturating at 2'b00. Target overwritten with upd_target only when taken.
  - Miss & taken: allocate or overwrite the entry: valid=1, tag, target=upd_target, counter=ALLOC_CTR.
  - Miss & not taken: no state change.
- mispredict (combinational) = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc + 4. Addition is modulo 2^ADDR_W, so the wrap from all-ones+4 is allowed. redirect_pc is driven 0 when upd_valid=0.
- upd_valid=0: no state change and mispredict=0, whatever the other upd_* inputs hold.
- Reset asserted mid-operation: state clears immediately. An update coinciding with a reset edge is discarded.
- Aliasing: tag mismatch counts as a miss; no replacement policy beyond direct overwrite.

Optional Feature:
- Macro: BP_STATS_EN.
- Defined:
  - Adds outputs stat_branches[31:0] (counts upd_valid cycles) and stat_mispred[31:0] (counts mispredict cycles).
  - Both reset to 0 on rst and saturate at 32'hFFFFFFFF (no wrap).
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset defaults: rst low, then high; lu_pc=32'h0000_0040 -> lu_hit=0, lu_taken=0, lu_target=0, mispredict=0.
- Allocate: upd_valid=1, upd_pc=32'h40, upd_taken=1, upd_target=32'h100, upd_pred_taken=0 -> same cycle mispredict=1, redirect_pc=32'h100. Next cycle lu_pc=32'h40 -> lu_hit=1, lu_taken=1, lu_target=32'h100.
- Counter saturation and not-taken redirect:
  - Two further taken updates to 32'h40 -> counter 2'b11.
  - Three not-taken updates -> counter 2'b00 and lu_taken=0; the first of these with upd_pred_taken=1 gives mispredict=1, redirect_pc=32'h44.
- Aliasing: with ENTRIES=16, after allocating 32'h40, lookup 32'h80 (same idx 0, different tag) -> lu_hit=0. Taken update at 32'h80 with target 32'h200 evicts the old entry, so a lookup of 32'h40 misses.
- Same-cycle conflict and target change:
  - Update 32'h40 taken with target 32'h300 while lu_pc=32'h40 -> old target 32'h100 shown that cycle, 32'h300 the next.
  - upd_pred_taken=1, upd_pred_target=32'h100 -> mispredict=1.
- With BP_STATS_EN: 5 updates of which 2 mispredict -> stat_branches=5, stat_mispred=2. rst low mid-run -> both 0 immediately.
